// File: rtl/snn_digit_decoder_if.sv
// Result port of the SNN digit decoder: a valid/ready channel carrying the
// winning class, its spike count and the tie/no-spike flags.
interface snn_digit_decoder_if #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 8
) ();
  logic             result_valid;
  logic             result_ready;
  logic [IDX_W-1:0] result_digit;
  logic [CNT_W-1:0] result_count;
  logic             result_tie;
  logic             result_none;

  modport master (
    output result_valid,
    input  result_ready,
    output result_digit,
    output result_count,
    output result_tie,
    output result_none
  );

  modport slave (
    input  result_valid,
    output result_ready,
    input  result_digit,
    input  result_count,
    input  result_tie,
    input  result_none
  );
endinterface

// File: rtl/snn_digit_decoder.sv
// Accumulates per-class output-layer spikes over a programmable window, then
// scans the counters one class per cycle to pick the winning digit.
module snn_digit_decoder #(
  parameter int OUTPUT_SIZE = 10,
  parameter int WIN_W       = 16,
  parameter int CNT_W       = 8,
  parameter int IDX_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [WIN_W-1:0]       window_len_i,
  input  logic [OUTPUT_SIZE-1:0] digit_spikes_i,
  output logic                   busy_o,
  snn_digit_decoder_if.master    result_if
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ARGMAX = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);

  state_e           state_q;
  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [CNT_W-1:0] cnt_q [OUTPUT_SIZE];
  logic [IDX_W-1:0] scan_idx_q;
  logic [CNT_W-1:0] max_q;
  logic [IDX_W-1:0] best_q;
  logic             tie_q;
  logic             busy_q;
  logic             valid_q;
  logic [IDX_W-1:0] digit_q;
  logic [CNT_W-1:0] count_q;
  logic             res_tie_q;
  logic             none_q;

  logic [CNT_W-1:0] cur_cnt_d;
  logic [CNT_W-1:0] max_d;
  logic [IDX_W-1:0] best_d;
  logic             tie_d;

  // One argmax step: strict greater-than replaces, so the lowest index keeps ties.
  always_comb begin
    cur_cnt_d = cnt_q[scan_idx_q];
    max_d     = max_q;
    best_d    = best_q;
    tie_d     = tie_q;
    if (cur_cnt_d > max_q) begin
      max_d  = cur_cnt_d;
      best_d = scan_idx_q;
      tie_d  = 1'b0;
    end else if ((cur_cnt_d == max_q) && (max_q != '0) && (scan_idx_q > best_q)) begin
      tie_d = 1'b1;
    end else begin
      tie_d = tie_q;
    end
  end

  // Window control, spike accumulation, argmax scan and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_len_q  <= '0;
      win_cnt_q  <= '0;
      for (int i = 0; i < OUTPUT_SIZE; i++) cnt_q[i] <= '0;
      scan_idx_q <= '0;
      max_q      <= '0;
      best_q     <= '0;
      tie_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      digit_q    <= '0;
      count_q    <= '0;
      res_tie_q  <= 1'b0;
      none_q     <= 1'b0;
    end else if (abort_i) begin
      // Counters are deliberately left alone; the next start clears them.
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && (window_len_i != '0)) begin
            win_len_q <= window_len_i;
            win_cnt_q <= '0;
            for (int i = 0; i < OUTPUT_SIZE; i++) cnt_q[i] <= '0;
            busy_q    <= 1'b1;
            state_q   <= ACCUM;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCUM: begin
          for (int i = 0; i < OUTPUT_SIZE; i++) begin
            if (digit_spikes_i[i] && (cnt_q[i] != CNT_MAX)) begin
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
          end
          if (win_cnt_q == (win_len_q - WIN_W'(1))) begin
            scan_idx_q <= '0;
            max_q      <= '0;
            best_q     <= '0;
            tie_q      <= 1'b0;
            state_q    <= ARGMAX;
          end else begin
            win_cnt_q <= win_cnt_q + WIN_W'(1);
          end
        end
        ARGMAX: begin
          max_q  <= max_d;
          best_q <= best_d;
          tie_q  <= tie_d;
          if (scan_idx_q == LAST_IDX) begin
            none_q    <= (max_d == '0);
            digit_q   <= (max_d == '0) ? '0 : best_d;
            count_q   <= max_d;
            res_tie_q <= (max_d == '0) ? 1'b0 : tie_d;
            valid_q   <= 1'b1;
            state_q   <= HOLD;
          end else begin
            scan_idx_q <= scan_idx_q + IDX_W'(1);
          end
        end
        HOLD: begin
          if (result_if.result_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= HOLD;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o                 = busy_q;
  assign result_if.result_valid = valid_q;
  assign result_if.result_digit = digit_q;
  assign result_if.result_count = count_q;
  assign result_if.result_tie   = res_tie_q;
  assign result_if.result_none  = none_q;

endmodule

// File: tb/tb_snn_digit_decoder.sv
// Directed self-checking bench for snn_digit_decoder: latency, ties,
// saturation, empty windows, result hold, abort and async reset.
module tb_snn_digit_decoder;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        abort_i;
  logic [15:0] window_len_i;
  logic [9:0]  digit_spikes_i;
  logic        busy_o;
  int          n_tests;
  int          n_fail;

  snn_digit_decoder_if #(.IDX_W(4), .CNT_W(8)) res_if ();

  snn_digit_decoder #(
    .OUTPUT_SIZE(10), .WIN_W(16), .CNT_W(8), .IDX_W(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .window_len_i   (window_len_i),
    .digit_spikes_i (digit_spikes_i),
    .busy_o         (busy_o),
    .result_if      (res_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_win(input logic [15:0] len);
    start_i      = 1'b1;
    window_len_i = len;
    tick();
    start_i      = 1'b0;
  endtask

  // Drives n samples: mask_odd on samples 1,3,5..., mask_even on 2,4,6...
  task automatic accum(input int n, input logic [9:0] mask_odd, input logic [9:0] mask_even);
    for (int k = 1; k <= n; k++) begin
      digit_spikes_i = (k % 2 == 0) ? mask_even : mask_odd;
      tick();
    end
    digit_spikes_i = '0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int cyc;
    cyc = 0;
    while (res_if.result_valid !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    check(tag, {31'd0, res_if.result_valid}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [3:0] d, input logic [7:0] c,
                              input logic t, input logic n);
    check({tag, "_digit"}, {28'd0, res_if.result_digit}, {28'd0, d});
    check({tag, "_count"}, {24'd0, res_if.result_count}, {24'd0, c});
    check({tag, "_tie"},   {31'd0, res_if.result_tie},   {31'd0, t});
    check({tag, "_none"},  {31'd0, res_if.result_none},  {31'd0, n});
  endtask

  task automatic handshake(input string tag);
    res_if.result_ready = 1'b1;
    tick();
    res_if.result_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, res_if.result_valid}, 32'd0);
    check({tag, "_busy_drop"},  {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    window_len_i = 16'd0; digit_spikes_i = 10'd0; res_if.result_ready = 1'b0;
    tick();
    tick();
    check("rst_busy",  {31'd0, busy_o}, 32'd0);
    check("rst_valid", {31'd0, res_if.result_valid}, 32'd0);
    check_result("rst", 4'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Window 20: class 3 every cycle, class 7 every 2nd; exact latency T+31.
    res_if.result_ready = 1'b1;
    start_win(16'd20);
    check("t1_busy", {31'd0, busy_o}, 32'd1);
    accum(20, 10'h008, 10'h088);
    check("t1_argmax_busy",  {31'd0, busy_o}, 32'd1);
    for (int k = 0; k < 9; k++) tick();
    check("t1_valid_T30", {31'd0, res_if.result_valid}, 32'd0);
    tick();
    check("t1_valid_T31", {31'd0, res_if.result_valid}, 32'd1);
    check_result("t1", 4'd3, 8'd20, 1'b0, 1'b0);
    tick();
    res_if.result_ready = 1'b0;
    check("t1_valid_drop", {31'd0, res_if.result_valid}, 32'd0);
    check("t1_busy_drop",  {31'd0, busy_o}, 32'd0);

    // Window 8: classes 2 and 5 four spikes each -> tie, lowest index wins.
    start_win(16'd8);
    accum(8, 10'h004, 10'h020);
    wait_valid("t2_valid", 20);
    check_result("t2", 4'd2, 8'd4, 1'b1, 1'b0);
    // Hold for 5 cycles with ready low; a start here must be ignored.
    for (int k = 0; k < 5; k++) begin
      start_i = 1'b1;
      window_len_i = 16'd5;
      tick();
      check("t5_hold_valid", {31'd0, res_if.result_valid}, 32'd1);
      check_result("t5_hold", 4'd2, 8'd4, 1'b1, 1'b0);
    end
    res_if.result_ready = 1'b1;
    tick();
    res_if.result_ready = 1'b0;
    start_i = 1'b0;
    check("t5_hs_valid", {31'd0, res_if.result_valid}, 32'd0);
    check("t5_hs_start_ignored", {31'd0, busy_o}, 32'd0);

    // Start accepted the cycle after the handshake: empty window of 10.
    start_win(16'd10);
    check("t4_busy", {31'd0, busy_o}, 32'd1);
    accum(10, 10'h000, 10'h000);
    wait_valid("t4_valid", 20);
    check_result("t4", 4'd0, 8'd0, 1'b0, 1'b1);
    handshake("t4");
    start_win(16'd0);
    check("t4_len0_busy", {31'd0, busy_o}, 32'd0);

    // Window 300: class 9 every cycle saturates at 255.
    start_win(16'd300);
    accum(300, 10'h200, 10'h200);
    wait_valid("t3_valid", 20);
    check_result("t3", 4'd9, 8'd255, 1'b0, 1'b0);
    handshake("t3");

    // Abort together with start: abort wins.
    start_i = 1'b1; abort_i = 1'b1; window_len_i = 16'd5;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    check("t6_abort_start", {31'd0, busy_o}, 32'd0);

    // Abort on cycle 5 of a 20-cycle window (class 1 spiking).
    start_win(16'd20);
    accum(4, 10'h002, 10'h002);
    digit_spikes_i = 10'h002;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    digit_spikes_i = 10'h000;
    check("t6_abort_busy",  {31'd0, busy_o}, 32'd0);
    check("t6_abort_valid", {31'd0, res_if.result_valid}, 32'd0);
    for (int k = 0; k < 25; k++) tick();
    check("t6_abort_no_result", {31'd0, res_if.result_valid}, 32'd0);

    // Clean run after abort: class 1 odd samples (3), class 6 all (6).
    start_win(16'd6);
    accum(6, 10'h042, 10'h040);
    wait_valid("t6a_valid", 20);
    check_result("t6a", 4'd6, 8'd6, 1'b0, 1'b0);
    handshake("t6a");

    // Async reset in the middle of the argmax scan.
    start_win(16'd3);
    accum(3, 10'h010, 10'h010);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",  {31'd0, busy_o}, 32'd0);
    check("t6_rst_valid", {31'd0, res_if.result_valid}, 32'd0);
    check_result("t6_rst", 4'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 15; k++) tick();
    check("t6_rst_no_result", {31'd0, res_if.result_valid}, 32'd0);

    // Clean run after reset: class 0 every cycle, class 8 on even samples.
    start_win(16'd4);
    accum(4, 10'h001, 10'h101);
    wait_valid("t6b_valid", 20);
    check_result("t6b", 4'd0, 8'd4, 1'b0, 1'b0);
    handshake("t6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
